// File: rtl/ff_pkg_311.sv
// Shared mode encodings for the ff_bank_311 storage bank and anything that drives it.
package ff_pkg_311;
   localparam logic [1:0] MODE_SR = 2'b00;
   localparam logic [1:0] MODE_JK = 2'b01;
   localparam logic [1:0] MODE_D  = 2'b10;
   localparam logic [1:0] MODE_T  = 2'b11;
endpackage

// File: rtl/ff_cell_311.sv
// Next-state logic for one bit of the bank; purely combinational.
// Flags S=R=1 in SR mode as illegal and holds q in that case.
module ff_cell_311
   import ff_pkg_311::*;
(
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   input  logic       q,
   output logic       q_next,
   output logic       illegal
);

   always_comb begin
      q_next  = q;
      illegal = 1'b0;
      case (mode)
         MODE_SR: begin
            if (a && b)  illegal = 1'b1;
            else if (a)  q_next  = 1'b1;
            else if (b)  q_next  = 1'b0;
         end
         MODE_JK: begin
            case ({a, b})
               2'b01:   q_next = 1'b0;
               2'b10:   q_next = 1'b1;
               2'b11:   q_next = ~q;
               default: q_next = q;
            endcase
         end
         MODE_D:  q_next = a;
         MODE_T:  q_next = q ^ a;
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/ff_bank_311.sv
// WIDTH-bit SR/JK/D/T flip-flop bank with parallel load, enable and illegal-SR tracking.
// One-clock latency; no backpressure. Priority: reset > load > hold (en=0) > mode operation.
module ff_bank_311
   import ff_pkg_311::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0,
   parameter int               CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_311,
   input  logic [1:0]       mode_311,
   input  logic [WIDTH-1:0] a_311,
   input  logic [WIDTH-1:0] b_311,
   input  logic             load_311,
   input  logic [WIDTH-1:0] ld_val_311,
   input  logic             err_clr_311,
   output logic [WIDTH-1:0] q_311,
   output logic [WIDTH-1:0] qb_311,
   output logic [WIDTH-1:0] err_flag_311,
   output logic [CNT_W-1:0] err_cnt_311
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_flag;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_illegal;
   logic             w_err_evt;
   logic             w_sat;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      ff_cell_311 u_cell (
         .mode    (mode_311),
         .a       (a_311[gi]),
         .b       (b_311[gi]),
         .q       (r_q[gi]),
         .q_next  (w_q_next[gi]),
         .illegal (w_illegal[gi])
      );
   end

   // Illegal bits only count when the SR operation would actually be applied.
   assign w_err_evt = en_311 && (mode_311 == MODE_SR) && !load_311 && (|w_illegal);
   assign w_sat     = &r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q    <= INIT;
         r_flag <= '0;
         r_cnt  <= '0;
      end else begin
         if (load_311)    r_q <= ld_val_311;
         else if (en_311) r_q <= w_q_next;

         // A clear coinciding with a new event leaves only that event recorded.
         if (err_clr_311) begin
            r_flag <= w_err_evt ? w_illegal : '0;
            r_cnt  <= w_err_evt ? CNT_W'(1) : '0;
         end else if (w_err_evt) begin
            r_flag <= r_flag | w_illegal;
            if (!w_sat) r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign q_311        = r_q;
   assign qb_311       = ~r_q;
   assign err_flag_311 = r_flag;
   assign err_cnt_311  = r_cnt;

endmodule

// File: tb/tb_ff_bank_311.sv
// Directed bench for ff_bank_311: reference model checked every cycle plus literal pins.
module tb_ff_bank_311;
   import ff_pkg_311::*;

   localparam int         W    = 8;
   localparam logic [7:0] INIT = 8'hA5;
   localparam int         CW   = 2;

   logic       clk = 1'b0;
   logic       reset, en, load, err_clr;
   logic [1:0] mode;
   logic [7:0] a, b, ld_val;
   logic [7:0] q, qb, flag;
   logic [1:0] cnt;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_on  = 1'b0;

   logic [7:0] m_q, m_flag;
   int         m_cnt;

   always #5 clk = ~clk;

   ff_bank_311 #(.WIDTH(W), .INIT(INIT), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .en_311       (en),
      .mode_311     (mode),
      .a_311        (a),
      .b_311        (b),
      .load_311     (load),
      .ld_val_311   (ld_val),
      .err_clr_311  (err_clr),
      .q_311        (q),
      .qb_311       (qb),
      .err_flag_311 (flag),
      .err_cnt_311  (cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: whole-word rules applied at each rising edge.
   always @(posedge clk) begin
      logic [7:0] ill;
      if (reset) begin
         m_q    = INIT;
         m_flag = 8'h00;
         m_cnt  = 0;
      end else begin
         if (err_clr) begin
            m_flag = 8'h00;
            m_cnt  = 0;
         end
         if (load) begin
            m_q = ld_val;
         end else if (en) begin
            if (mode == MODE_SR) begin
               ill = a & b;
               m_q = (m_q | (a & ~b)) & ~(b & ~a);
               if (ill != 8'h00) begin
                  m_flag = m_flag | ill;
                  if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
               end
            end else if (mode == MODE_JK) begin
               for (int i = 0; i < W; i++) begin
                  if (a[i] && b[i])  m_q[i] = ~m_q[i];
                  else if (a[i])     m_q[i] = 1'b1;
                  else if (b[i])     m_q[i] = 1'b0;
               end
            end else if (mode == MODE_D) begin
               m_q = a;
            end else begin
               m_q = m_q ^ a;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_q",    {24'd0, q},    {24'd0, m_q});
         chk("model_qb",   {24'd0, qb},   {24'd0, ~m_q});
         chk("model_flag", {24'd0, flag}, {24'd0, m_flag});
         chk("model_cnt",  {30'd0, cnt},  32'(m_cnt));
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic lit(input string nm, input logic [7:0] eq, input logic [7:0] ef, input logic [1:0] ec);
      chk({nm, "_q"},    {24'd0, q},    {24'd0, eq});
      chk({nm, "_flag"}, {24'd0, flag}, {24'd0, ef});
      chk({nm, "_cnt"},  {30'd0, cnt},  {30'd0, ec});
   endtask

   typedef struct {
      logic [1:0] md;
      logic       e;
      logic       ld;
      logic       clr;
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] vl;
   } vec_t;

   vec_t tbl[8];

   initial begin
      reset = 1'b1; en = 1'b0; load = 1'b0; err_clr = 1'b0;
      mode = MODE_SR; a = 8'h00; b = 8'h00; ld_val = 8'h00;
      @(negedge clk);
      step();
      step();
      lit("reset", 8'hA5, 8'h00, 2'd0);
      chk("reset_qb", {24'd0, qb}, 32'h5A);
      cmp_on = 1'b1;

      reset = 1'b0;
      step();                         lit("release_hold", 8'hA5, 8'h00, 2'd0);
      load = 1'b1; ld_val = 8'h00;
      step();                         lit("load00", 8'h00, 8'h00, 2'd0);
      load = 1'b0;

      en = 1'b1; mode = MODE_SR;
      a = 8'h0F; b = 8'h00; step();   lit("sr_set", 8'h0F, 8'h00, 2'd0);
      a = 8'h00; b = 8'h03; step();   lit("sr_rst", 8'h0C, 8'h00, 2'd0);
      a = 8'h11; b = 8'h11; step();   lit("sr_ill", 8'h0C, 8'h11, 2'd1);

      mode = MODE_JK; a = 8'hFF; b = 8'hFF;
      step();                         lit("jk_tog1", 8'hF3, 8'h11, 2'd1);
      step();                         lit("jk_tog2", 8'h0C, 8'h11, 2'd1);
      mode = MODE_T; a = 8'h01; b = 8'h00;
      step();                         lit("t1", 8'h0D, 8'h11, 2'd1);
      step();                         lit("t2", 8'h0C, 8'h11, 2'd1);
      step();                         lit("t3", 8'h0D, 8'h11, 2'd1);
      mode = MODE_D; a = 8'h3C;
      step();                         lit("d", 8'h3C, 8'h11, 2'd1);

      load = 1'b1; ld_val = 8'h99; a = 8'h00;
      step();                         lit("load_prio", 8'h99, 8'h11, 2'd1);
      load = 1'b0; en = 1'b0; a = 8'hFF;
      step();                         lit("en_hold", 8'h99, 8'h11, 2'd1);

      err_clr = 1'b1;
      step();                         lit("clr1", 8'h99, 8'h00, 2'd0);
      err_clr = 1'b0; en = 1'b1; mode = MODE_SR; a = 8'hFF; b = 8'hFF;
      for (int i = 0; i < 5; i++) step();
      lit("sat", 8'h99, 8'hFF, 2'd3);
      err_clr = 1'b1; a = 8'h01; b = 8'h01;
      step();                         lit("clr_evt", 8'h99, 8'h01, 2'd1);
      en = 1'b0;
      step();                         lit("clr2", 8'h99, 8'h00, 2'd0);

      err_clr = 1'b0; en = 1'b1; a = 8'h02; b = 8'h02;
      step();                         lit("ill2", 8'h99, 8'h02, 2'd1);
      load = 1'b1; ld_val = 8'hF0; a = 8'hFF; b = 8'hFF;
      step();                         lit("load_keeps_err", 8'hF0, 8'h02, 2'd1);

      reset = 1'b1; ld_val = 8'hFF;
      step();                         lit("reset_mid", 8'hA5, 8'h00, 2'd0);
      reset = 1'b0; load = 1'b0; en = 1'b0;

      tbl[0] = '{MODE_SR, 1'b1, 1'b0, 1'b0, 8'h05, 8'h07, 8'h00};
      tbl[1] = '{MODE_JK, 1'b1, 1'b0, 1'b0, 8'h0F, 8'hF0, 8'h00};
      tbl[2] = '{MODE_T,  1'b1, 1'b0, 1'b1, 8'hAA, 8'h55, 8'h00};
      tbl[3] = '{MODE_SR, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00};
      tbl[4] = '{MODE_SR, 1'b1, 1'b0, 1'b0, 8'hC0, 8'hC3, 8'h00};
      tbl[5] = '{MODE_JK, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h00};
      tbl[6] = '{MODE_D,  1'b1, 1'b1, 1'b0, 8'h12, 8'h00, 8'h6E};
      tbl[7] = '{MODE_SR, 1'b1, 1'b0, 1'b1, 8'h80, 8'h80, 8'h00};
      foreach (tbl[i]) begin
         mode = tbl[i].md; en = tbl[i].e; load = tbl[i].ld; err_clr = tbl[i].clr;
         a = tbl[i].va; b = tbl[i].vb; ld_val = tbl[i].vl;
         step();
      end
      lit("tbl_end", 8'h6E, 8'h80, 2'd1);

      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
